// File: rtl/glb_interrupt_collector.sv
// glb_interrupt_collector
//   Gathers per-tile interrupt pulses from all global buffer tiles into
//   sticky write-1-to-clear status registers and saturating per-class event
//   counters. It drives one level interrupt, gated by a per-class enable mask.
//
// Ports
//   clk, reset                  clock and asynchronous active-high reset
//   strm_f2g_interrupt_pulse    per-tile f2g-done pulses (1 cycle each)
//   strm_g2f_interrupt_pulse    per-tile g2f-done pulses
//   pcfg_g2f_interrupt_pulse    per-tile parallel-config-done pulses
//   cfg_wr_en/addr/data         single-beat register write port
//   cfg_rd_en/addr              single-beat register read request
//   cfg_rd_data/_valid          registered read response, one cycle after request
//   interrupt                   registered level interrupt to the processor
//
// Register map (word address)
//   0x0 IER (RW, bits[2:0] = {pcfg, g2f, f2g})   0x1 ISR (RO)
//   0x2/0x3/0x4 F2G/G2F/PCFG_STATUS (W1C)
//   0x5/0x6/0x7 F2G/G2F/PCFG_COUNT (any write clears)
module glb_interrupt_collector #(
  parameter int NUM_GLB_TILES  = 16,
  parameter int CFG_ADDR_WIDTH = 4,
  parameter int CFG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_GLB_TILES-1:0]  strm_f2g_interrupt_pulse,
  input  logic [NUM_GLB_TILES-1:0]  strm_g2f_interrupt_pulse,
  input  logic [NUM_GLB_TILES-1:0]  pcfg_g2f_interrupt_pulse,
  input  logic                      cfg_wr_en,
  input  logic [CFG_ADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic [CFG_DATA_WIDTH-1:0] cfg_wr_data,
  input  logic                      cfg_rd_en,
  input  logic [CFG_ADDR_WIDTH-1:0] cfg_rd_addr,
  output logic [CFG_DATA_WIDTH-1:0] cfg_rd_data,
  output logic                      cfg_rd_data_valid,
  output logic                      interrupt
);

  localparam int CNT_W = 16;
  localparam int POP_W = 6;  // holds popcount up to 32 tiles

  localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_IER        = CFG_ADDR_WIDTH'(0);
  localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_ISR        = CFG_ADDR_WIDTH'(1);
  localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_F2G_STATUS = CFG_ADDR_WIDTH'(2);
  localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_G2F_STATUS = CFG_ADDR_WIDTH'(3);
  localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_PCFG_STATUS= CFG_ADDR_WIDTH'(4);
  localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_F2G_COUNT  = CFG_ADDR_WIDTH'(5);
  localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_G2F_COUNT  = CFG_ADDR_WIDTH'(6);
  localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_PCFG_COUNT = CFG_ADDR_WIDTH'(7);

  logic [NUM_GLB_TILES-1:0] f2g_q, g2f_q, pcfg_q;
  logic [NUM_GLB_TILES-1:0] f2g_status, g2f_status, pcfg_status;
  logic [CNT_W-1:0]         f2g_count, g2f_count, pcfg_count;
  logic [2:0]               ier;
  logic [2:0]               isr;
  logic [CFG_DATA_WIDTH-1:0] rd_mux;

  logic wr_ier, wr_f2g_st, wr_g2f_st, wr_pcfg_st;
  logic wr_f2g_cnt, wr_g2f_cnt, wr_pcfg_cnt;

  // Data bits beyond the widest register field are don't-care on writes.
  logic unused_wr_data;
  assign unused_wr_data = ^cfg_wr_data;

  assign wr_ier      = cfg_wr_en && (cfg_wr_addr == ADDR_IER);
  assign wr_f2g_st   = cfg_wr_en && (cfg_wr_addr == ADDR_F2G_STATUS);
  assign wr_g2f_st   = cfg_wr_en && (cfg_wr_addr == ADDR_G2F_STATUS);
  assign wr_pcfg_st  = cfg_wr_en && (cfg_wr_addr == ADDR_PCFG_STATUS);
  assign wr_f2g_cnt  = cfg_wr_en && (cfg_wr_addr == ADDR_F2G_COUNT);
  assign wr_g2f_cnt  = cfg_wr_en && (cfg_wr_addr == ADDR_G2F_COUNT);
  assign wr_pcfg_cnt = cfg_wr_en && (cfg_wr_addr == ADDR_PCFG_COUNT);

  assign isr = {|pcfg_status, |g2f_status, |f2g_status};

  function automatic logic [POP_W-1:0] popcount(input logic [NUM_GLB_TILES-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_GLB_TILES; i++) c = c + POP_W'(v[i]);
    return c;
  endfunction

  // A clear in the same cycle as new events restarts from the new events,
  // so they are not lost.
  function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0]         cur,
                                                  input logic [NUM_GLB_TILES-1:0] p,
                                                  input logic                     clr);
    logic [CNT_W:0]   sum;
    logic [POP_W-1:0] pc;
    pc  = popcount(p);
    sum = {1'b0, cur} + (CNT_W+1)'(pc);
    if (clr)           return CNT_W'(pc);
    else if (sum[CNT_W]) return '1;
    else               return sum[CNT_W-1:0];
  endfunction

  // New pulses take priority over a write-1-to-clear of the same bit.
  function automatic logic [NUM_GLB_TILES-1:0] status_next(input logic [NUM_GLB_TILES-1:0] cur,
                                                           input logic [NUM_GLB_TILES-1:0] p,
                                                           input logic                     hit);
    return p | (cur & ~({NUM_GLB_TILES{hit}} & cfg_wr_data[NUM_GLB_TILES-1:0]));
  endfunction

  always_comb begin
    rd_mux = '0;
    case (cfg_rd_addr)
      ADDR_IER:         rd_mux = CFG_DATA_WIDTH'(ier);
      ADDR_ISR:         rd_mux = CFG_DATA_WIDTH'(isr);
      ADDR_F2G_STATUS:  rd_mux = CFG_DATA_WIDTH'(f2g_status);
      ADDR_G2F_STATUS:  rd_mux = CFG_DATA_WIDTH'(g2f_status);
      ADDR_PCFG_STATUS: rd_mux = CFG_DATA_WIDTH'(pcfg_status);
      ADDR_F2G_COUNT:   rd_mux = CFG_DATA_WIDTH'(f2g_count);
      ADDR_G2F_COUNT:   rd_mux = CFG_DATA_WIDTH'(g2f_count);
      ADDR_PCFG_COUNT:  rd_mux = CFG_DATA_WIDTH'(pcfg_count);
      default:          rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f2g_q             <= '0;
      g2f_q             <= '0;
      pcfg_q            <= '0;
      f2g_status        <= '0;
      g2f_status        <= '0;
      pcfg_status       <= '0;
      f2g_count         <= '0;
      g2f_count         <= '0;
      pcfg_count        <= '0;
      ier               <= '0;
      interrupt         <= 1'b0;
      cfg_rd_data       <= '0;
      cfg_rd_data_valid <= 1'b0;
    end else begin
      f2g_q  <= strm_f2g_interrupt_pulse;
      g2f_q  <= strm_g2f_interrupt_pulse;
      pcfg_q <= pcfg_g2f_interrupt_pulse;

      f2g_status  <= status_next(f2g_status,  f2g_q,  wr_f2g_st);
      g2f_status  <= status_next(g2f_status,  g2f_q,  wr_g2f_st);
      pcfg_status <= status_next(pcfg_status, pcfg_q, wr_pcfg_st);

      f2g_count  <= count_next(f2g_count,  f2g_q,  wr_f2g_cnt);
      g2f_count  <= count_next(g2f_count,  g2f_q,  wr_g2f_cnt);
      pcfg_count <= count_next(pcfg_count, pcfg_q, wr_pcfg_cnt);

      if (wr_ier) ier <= cfg_wr_data[2:0];

      // Driven from the registered status/enable, one stage after they settle.
      interrupt <= |(isr & ier);

      // Reads sample the registers before this edge's updates.
      cfg_rd_data_valid <= cfg_rd_en;
      if (cfg_rd_en) cfg_rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_glb_interrupt_collector.sv
module tb_glb_interrupt_collector;

  logic        clk;
  logic        reset;
  logic [15:0] f2g, g2f, pcfg;
  logic        cfg_wr_en;
  logic [3:0]  cfg_wr_addr;
  logic [31:0] cfg_wr_data;
  logic        cfg_rd_en;
  logic [3:0]  cfg_rd_addr;
  logic [31:0] cfg_rd_data;
  logic        cfg_rd_data_valid;
  logic        interrupt;

  int unsigned n_checks;
  int unsigned n_fail;

  glb_interrupt_collector #(
    .NUM_GLB_TILES (16),
    .CFG_ADDR_WIDTH(4),
    .CFG_DATA_WIDTH(32)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .strm_f2g_interrupt_pulse(f2g),
    .strm_g2f_interrupt_pulse(g2f),
    .pcfg_g2f_interrupt_pulse(pcfg),
    .cfg_wr_en               (cfg_wr_en),
    .cfg_wr_addr             (cfg_wr_addr),
    .cfg_wr_data             (cfg_wr_data),
    .cfg_rd_en               (cfg_rd_en),
    .cfg_rd_addr             (cfg_rd_addr),
    .cfg_rd_data             (cfg_rd_data),
    .cfg_rd_data_valid       (cfg_rd_data_valid),
    .interrupt               (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[9];

  // Each cycle begins 1 time unit after the rising edge; inputs are driven
  // and outputs sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = a;
    cfg_wr_data = d;
    tick();
    cfg_wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
    cfg_rd_en   = 1'b1;
    cfg_rd_addr = a;
    tick();
    cfg_rd_en   = 1'b0;
    check({nm, "_valid"}, {31'd0, cfg_rd_data_valid}, 32'd1);
    check(nm, cfg_rd_data, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    f2g = '0; g2f = '0; pcfg = '0;
    cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    cfg_rd_en = 1'b0; cfg_rd_addr = '0;

    tbl[0] = '{4'h0, 32'hFFFF_FFFF, 32'h7};
    tbl[1] = '{4'h0, 32'h0000_0005, 32'h5};
    tbl[2] = '{4'h0, 32'h0000_0000, 32'h0};
    tbl[3] = '{4'h1, 32'hFFFF_FFFF, 32'h0};
    tbl[4] = '{4'h2, 32'hFFFF_FFFF, 32'h0};
    tbl[5] = '{4'h5, 32'h0000_1234, 32'h0};
    tbl[6] = '{4'h8, 32'hFFFF_FFFF, 32'h0};
    tbl[7] = '{4'hF, 32'h0000_A5A5, 32'h0};
    tbl[8] = '{4'h0, 32'h0000_0001, 32'h1};

    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state: every address reads 0, valid is a single-cycle pulse.
    check("rst_int", {31'd0, interrupt}, 32'd0);
    check("rst_valid", {31'd0, cfg_rd_data_valid}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), 32'h0, $sformatf("rst_rd%0d", a));
      tick();
      check($sformatf("rst_vlow%0d", a), {31'd0, cfg_rd_data_valid}, 32'd0);
    end

    // Write/readback vectors.
    for (int i = 0; i < 9; i++) begin
      wr(tbl[i].addr, tbl[i].data);
      rd(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));
    end
    check("tbl_int", {31'd0, interrupt}, 32'd0);

    // f2g tile 3 with IER=1: interrupt rises at t+3.
    f2g = 16'h0008;
    tick();
    f2g = '0;
    check("f2g_int_t1", {31'd0, interrupt}, 32'd0);
    tick();
    check("f2g_int_t2", {31'd0, interrupt}, 32'd0);
    tick();
    check("f2g_int_t3", {31'd0, interrupt}, 32'd1);
    rd(4'h2, 32'h8, "f2g_status");
    rd(4'h1, 32'h1, "f2g_isr");
    rd(4'h5, 32'h1, "f2g_count");
    wr(4'h2, 32'h8);
    check("w1c_int_t1", {31'd0, interrupt}, 32'd1);
    tick();
    check("w1c_int_t2", {31'd0, interrupt}, 32'd0);
    rd(4'h2, 32'h0, "f2g_status_clr");

    // Same pulse with IER=0, then enable.
    wr(4'h0, 32'h0);
    f2g = 16'h0008;
    tick();
    f2g = '0;
    repeat (4) tick();
    check("ier0_int", {31'd0, interrupt}, 32'd0);
    rd(4'h2, 32'h8, "ier0_status");
    wr(4'h0, 32'h1);
    check("ier_int_t1", {31'd0, interrupt}, 32'd0);
    tick();
    check("ier_int_t2", {31'd0, interrupt}, 32'd1);
    rd(4'h5, 32'h2, "f2g_count2");
    wr(4'h2, 32'h8);
    wr(4'h0, 32'h0);

    // g2f tile 5: W1C coinciding with a new pulse at the update edge.
    g2f = 16'h0020;
    tick();
    g2f = '0;
    tick(); tick();
    rd(4'h3, 32'h20, "g2f_set");
    g2f = 16'h0020;
    tick();
    g2f = '0;
    wr(4'h3, 32'h20);
    rd(4'h3, 32'h20, "g2f_collide");
    wr(4'h3, 32'h20);
    rd(4'h3, 32'h0, "g2f_w1c");
    rd(4'h6, 32'h2, "g2f_count");

    // pcfg saturation: 4100 cycles of 16 pulses each.
    pcfg = 16'hFFFF;
    repeat (4100) tick();
    pcfg = '0;
    tick(); tick();
    rd(4'h7, 32'hFFFF, "pcfg_sat");
    rd(4'h4, 32'hFFFF, "pcfg_status");
    rd(4'h1, 32'h4, "pcfg_isr");
    pcfg = 16'hFFFF;
    tick();
    pcfg = '0;
    wr(4'h7, 32'h0);
    rd(4'h7, 32'h10, "pcfg_clr_collide");
    wr(4'h7, 32'hDEAD);
    rd(4'h7, 32'h0, "pcfg_clr");

    // Read and write of the same address at the same edge: old value.
    wr(4'h0, 32'h1);
    cfg_wr_en = 1'b1; cfg_wr_addr = 4'h0; cfg_wr_data = 32'h6;
    cfg_rd_en = 1'b1; cfg_rd_addr = 4'h0;
    tick();
    cfg_wr_en = 1'b0; cfg_rd_en = 1'b0;
    check("rw_same_valid", {31'd0, cfg_rd_data_valid}, 32'd1);
    check("rw_same_old", cfg_rd_data, 32'h1);
    rd(4'h0, 32'h6, "rw_same_new");

    // Back-to-back reads, then data holds.
    cfg_rd_en = 1'b1; cfg_rd_addr = 4'h0;
    tick();
    check("b2b_v1", {31'd0, cfg_rd_data_valid}, 32'd1);
    check("b2b_d1", cfg_rd_data, 32'h6);
    cfg_rd_addr = 4'h4;
    tick();
    cfg_rd_en = 1'b0;
    check("b2b_v2", {31'd0, cfg_rd_data_valid}, 32'd1);
    check("b2b_d2", cfg_rd_data, 32'hFFFF);
    tick();
    check("b2b_vlow", {31'd0, cfg_rd_data_valid}, 32'd0);
    check("b2b_hold", cfg_rd_data, 32'hFFFF);
    check("pre_rst_int", {31'd0, interrupt}, 32'd1);

    // Asynchronous reset between a read request and its response.
    cfg_rd_en = 1'b1; cfg_rd_addr = 4'h4;
    pcfg = 16'hFFFF;
    #2;
    reset = 1'b1;
    #1;
    check("arst_int", {31'd0, interrupt}, 32'd0);
    check("arst_data", cfg_rd_data, 32'h0);
    tick();
    cfg_rd_en = 1'b0;
    pcfg = '0;
    check("arst_novalid", {31'd0, cfg_rd_data_valid}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("arst_valid_after", {31'd0, cfg_rd_data_valid}, 32'd0);
    check("arst_int_after", {31'd0, interrupt}, 32'd0);
    for (int a = 0; a < 8; a++) rd(4'(a), 32'h0, $sformatf("arst_rd%0d", a));
    tick(); tick();
    check("arst_int_end", {31'd0, interrupt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
